// File: rtl/vend_dispense_ctrl.sv
// Vending sequencing controller: coin credit accumulation, price check on selection,
// timed dispense pulse, then unit-by-unit change payout before a one-cycle done strobe.
module vend_dispense_ctrl #(
    parameter int PULSE_CYC  = 4,
    parameter int GAP_CYC    = 2,
    parameter int MAX_CREDIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid_i,
    input  logic [1:0] coin_i,
    input  logic       sel_valid_i,
    input  logic [1:0] sel_i,
    output logic [3:0] credit_o,
    output logic       disp_en_o,
    output logic [1:0] disp_id_o,
    output logic       chg_pulse_o,
    output logic       coin_reject_o,
    output logic       err_insuf_o,
    output logic       busy_o,
    output logic       listo_o
);

    localparam int TMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int TW   = $clog2(TMAX) + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DISP = 3'd1,
        GAP  = 3'd2,
        CHG  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    credit_q, credit_d;
    logic [1:0]    disp_id_q, disp_id_d;
    logic          coin_reject_q, coin_reject_d;
    logic          err_insuf_q, err_insuf_d;
    logic          disp_en_q, chg_pulse_q, busy_q, listo_q;
    logic [4:0]    coin_sum_s;
    logic [3:0]    price_s;

    function automatic logic [3:0] coin_value(input logic [1:0] code);
        case (code)
            2'b00:   coin_value = 4'd0;
            2'b01:   coin_value = 4'd1;
            2'b10:   coin_value = 4'd2;
            default: coin_value = 4'd5;
        endcase
    endfunction

    function automatic logic [3:0] price_of(input logic [1:0] code);
        case (code)
            2'b00:   price_of = 4'd0;
            2'b01:   price_of = 4'd2;
            2'b10:   price_of = 4'd3;
            default: price_of = 4'd5;
        endcase
    endfunction

    // Next-state, timer, credit and strobe decisions.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        credit_d      = credit_q;
        disp_id_d     = 2'b00;
        err_insuf_d   = 1'b0;
        coin_reject_d = coin_valid_i && (state_q != IDLE);
        coin_sum_s    = {1'b0, credit_q} + {1'b0, coin_value(coin_i)};
        price_s       = price_of(sel_i);
        case (state_q)
            IDLE: begin
                timer_d = '0;
                // A coin colliding with a selection is returned; the selection sees pre-coin credit.
                if (coin_valid_i && (coin_i != 2'b00)) begin
                    if (sel_valid_i || (coin_sum_s > 5'(MAX_CREDIT))) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = coin_sum_s[3:0];
                    end
                end else begin
                    coin_reject_d = 1'b0;
                end
                if (sel_valid_i) begin
                    if (sel_i == 2'b00) begin
                        if (credit_q != 4'd0) begin
                            state_d = GAP;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (credit_q >= price_s) begin
                        state_d   = DISP;
                        credit_d  = credit_q - price_s;
                        disp_id_d = sel_i;
                    end else begin
                        err_insuf_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DISP: begin
                disp_id_d = disp_id_q;
                if (timer_q == TW'(PULSE_CYC - 1)) begin
                    state_d   = GAP;
                    timer_d   = '0;
                    disp_id_d = 2'b00;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            GAP: begin
                if (timer_q == TW'(GAP_CYC - 1)) begin
                    timer_d = '0;
                    state_d = (credit_q != 4'd0) ? CHG : DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            CHG: begin
                if (timer_q == TW'(PULSE_CYC - 1)) begin
                    state_d  = GAP;
                    timer_d  = '0;
                    credit_d = credit_q - 4'd1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DONE: begin
                state_d  = IDLE;
                timer_d  = '0;
                credit_d = 4'd0;
            end
            default: begin
                state_d  = IDLE;
                timer_d  = '0;
                credit_d = 4'd0;
            end
        endcase
    end

    // State, datapath and output registers; outputs decode the next state so they are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            credit_q      <= 4'd0;
            disp_id_q     <= 2'b00;
            coin_reject_q <= 1'b0;
            err_insuf_q   <= 1'b0;
            disp_en_q     <= 1'b0;
            chg_pulse_q   <= 1'b0;
            busy_q        <= 1'b0;
            listo_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            credit_q      <= credit_d;
            disp_id_q     <= disp_id_d;
            coin_reject_q <= coin_reject_d;
            err_insuf_q   <= err_insuf_d;
            disp_en_q     <= (state_d == DISP);
            chg_pulse_q   <= (state_d == CHG);
            busy_q        <= (state_d != IDLE);
            listo_q       <= (state_d == DONE);
        end
    end

    assign credit_o      = credit_q;
    assign disp_en_o     = disp_en_q;
    assign disp_id_o     = disp_id_q;
    assign chg_pulse_o   = chg_pulse_q;
    assign coin_reject_o = coin_reject_q;
    assign err_insuf_o   = err_insuf_q;
    assign busy_o        = busy_q;
    assign listo_o       = listo_q;

endmodule
